// File: rtl/ps_pl_cmd_launcher_if.sv
// Command handshake between the launcher and the transformer core.
// The launcher offers cmd_arg/cmd_op under valid/ready; the core answers with a done pulse.
interface ps_pl_cmd_launcher_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_arg;
  logic [DATA_WIDTH-1:0] cmd_op;
  logic                  core_done;

  modport master (
    output cmd_valid,
    output cmd_arg,
    output cmd_op,
    input  cmd_ready,
    input  core_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_arg,
    input  cmd_op,
    output cmd_ready,
    output core_done
  );
endinterface

// File: rtl/ps_pl_cmd_launcher.sv
// Queues two-word PS commands from register-write strobes and issues them one at a time
// to the core, waiting for core_done between commands; exposes status and a level irq.
module ps_pl_cmd_launcher #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    reg_wr_en,
  input  logic [1:0]              reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]   reg_wr_data,
  output logic [31:0]             status_word,
  ps_pl_cmd_launcher_if.master    cmd_bus,
  output logic                    irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [1:0]              state;
  logic [DATA_WIDTH-1:0]   arg_stage;
  logic                    irq_en;
  logic                    irq_pending;
  logic                    overflow;
  logic [15:0]             done_cnt;

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [2*DATA_WIDTH-1:0] head;

  logic ctrl_wr, soft_clear, irq_ack, arg_wr, push_req;
  logic fifo_full, fifo_empty, pop, push_ok, done_hit;

  always_comb begin
    ctrl_wr    = reg_wr_en && (reg_wr_addr == 2'd0);
    soft_clear = ctrl_wr && reg_wr_data[0];
    irq_ack    = ctrl_wr && reg_wr_data[2];
    arg_wr     = reg_wr_en && (reg_wr_addr == 2'd1);
    push_req   = reg_wr_en && (reg_wr_addr == 2'd2);
    fifo_full  = (count == DEPTH_C);
    fifo_empty = (count == '0);
    pop        = (state == S_ISSUE) && cmd_bus.cmd_valid && cmd_bus.cmd_ready;
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    push_ok    = push_req && (!fifo_full || pop);
    done_hit   = (state == S_WAIT_DONE) && cmd_bus.core_done;
    head       = mem[rd_ptr];
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem[wr_ptr] <= {arg_stage, reg_wr_data};
  end

  // irq_en survives soft_clear, so a CTRL write carrying soft_clear leaves it untouched.
  always_ff @(posedge ACLK) begin
    if (ARESET) irq_en <= 1'b0;
    else if (ctrl_wr && !reg_wr_data[0]) irq_en <= reg_wr_data[1];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || soft_clear) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      arg_stage         <= '0;
      overflow          <= 1'b0;
      irq_pending       <= 1'b0;
      done_cnt          <= '0;
      state             <= S_IDLE;
      cmd_bus.cmd_valid <= 1'b0;
      cmd_bus.cmd_arg   <= '0;
      cmd_bus.cmd_op    <= '0;
    end else begin
      if (arg_wr) arg_stage <= reg_wr_data;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;

      if (done_hit && irq_en) irq_pending <= 1'b1;
      else if (irq_ack)       irq_pending <= 1'b0;

      if (done_hit) done_cnt <= done_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd_bus.cmd_arg   <= head[2*DATA_WIDTH-1:DATA_WIDTH];
            cmd_bus.cmd_op    <= head[DATA_WIDTH-1:0];
            cmd_bus.cmd_valid <= 1'b1;
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pop) begin
            cmd_bus.cmd_valid <= 1'b0;
            state             <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (cmd_bus.core_done) state <= S_IDLE;
        end
        default: begin
          cmd_bus.cmd_valid <= 1'b0;
          state             <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      status_word <= 32'h0000_0002;
    end else begin
      status_word <= {done_cnt, 8'(count), 3'b000, irq_pending, overflow,
                      fifo_full, fifo_empty, (state != S_IDLE)};
    end
  end

  assign irq = irq_pending & irq_en;

endmodule

// File: tb/tb_ps_pl_cmd_launcher.sv
// Directed bench for ps_pl_cmd_launcher: a register-write vector table for the fill/overflow
// path plus hand-written sequences for issue order, irq, full push/pop, soft_clear and wrap.
module tb_ps_pl_cmd_launcher;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        reg_wr_en;
  logic [1:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] status_word;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ps_pl_cmd_launcher_if #(.DATA_WIDTH(32)) bus ();

  ps_pl_cmd_launcher #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .status_word (status_word),
    .cmd_bus     (bus),
    .irq         (irq)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_status;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    reg_wr_en   = 1'b1;
    reg_wr_addr = addr;
    reg_wr_data = data;
    tick(1);
    reg_wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    bus.core_done = 1'b1;
    tick(1);
    bus.core_done = 1'b0;
  endtask

  task automatic do_reset();
    ARESET        = 1'b1;
    reg_wr_en     = 1'b0;
    reg_wr_addr   = '0;
    reg_wr_data   = '0;
    bus.cmd_ready = 1'b0;
    bus.core_done = 1'b0;
    tick(2);
    ARESET = 1'b0;
  endtask

  // Waits (bounded) for cmd_valid, checks the offered words, lets it pop, then completes it.
  task automatic run_one(input string name, input logic [31:0] exp_arg, input logic [31:0] exp_op);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_valid) break;
      tick(1);
    end
    chk({name, "_valid"}, {31'd0, bus.cmd_valid}, 32'd1);
    chk({name, "_arg"}, bus.cmd_arg, exp_arg);
    chk({name, "_op"}, bus.cmd_op, exp_op);
    tick(1);
    bus.cmd_ready = 1'b0;
    pulse_done();
  endtask

  initial begin
    vecs[0]  = '{2'd1, 32'hA5A5_0000, 32'h0000_0002, 1'b0};
    vecs[1]  = '{2'd2, 32'h0000_0010, 32'h0000_0101, 1'b0};
    vecs[2]  = '{2'd2, 32'h0000_0011, 32'h0000_0201, 1'b0};
    vecs[3]  = '{2'd2, 32'h0000_0012, 32'h0000_0301, 1'b0};
    vecs[4]  = '{2'd2, 32'h0000_0013, 32'h0000_0401, 1'b0};
    vecs[5]  = '{2'd2, 32'h0000_0014, 32'h0000_0501, 1'b0};
    vecs[6]  = '{2'd2, 32'h0000_0015, 32'h0000_0601, 1'b0};
    vecs[7]  = '{2'd2, 32'h0000_0016, 32'h0000_0701, 1'b0};
    vecs[8]  = '{2'd2, 32'h0000_0017, 32'h0000_0805, 1'b0};
    vecs[9]  = '{2'd2, 32'h0000_0018, 32'h0000_080D, 1'b0};
    vecs[10] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_080D, 1'b0};
    vecs[11] = '{2'd0, 32'h0000_0002, 32'h0000_080D, 1'b0};

    // Reset state and first-command latency
    do_reset();
    chk("rst_status", status_word, 32'h0000_0002);
    chk("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("rst_arg", bus.cmd_arg, 32'd0);
    chk("rst_op", bus.cmd_op, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    bus.cmd_ready = 1'b1;
    wr(2'd1, 32'hA5A5_0001);
    wr(2'd2, 32'h0000_0010);
    chk("lat_valid_n1", {31'd0, bus.cmd_valid}, 32'd0);
    tick(1);
    chk("lat_valid_n2", {31'd0, bus.cmd_valid}, 32'd1);
    chk("lat_arg", bus.cmd_arg, 32'hA5A5_0001);
    chk("lat_op", bus.cmd_op, 32'h0000_0010);
    tick(1);
    chk("lat_popped", {31'd0, bus.cmd_valid}, 32'd0);
    pulse_done();
    tick(2);
    chk("first_done_status", status_word, 32'h0001_0002);

    // Fill past depth with the core stalled
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      tick(2);
      chk($sformatf("vec%0d_status", i), status_word, vecs[i].exp_status);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // Drain in push order; the dropped ninth entry never appears
    for (int k = 0; k < 8; k++) begin
      run_one($sformatf("drain%0d", k), 32'hA5A5_0000, 32'h10 + k);
      chk($sformatf("drain%0d_gap", k), {31'd0, bus.cmd_valid}, 32'd0);
    end
    tick(3);
    chk("drain_status", status_word, 32'h0008_001A);
    chk("drain_irq", {31'd0, irq}, 32'd1);
    chk("drain_no_extra", {31'd0, bus.cmd_valid}, 32'd0);

    // irq acknowledge and masking
    wr(2'd0, 32'h0000_0004);
    tick(2);
    chk("ack_irq", {31'd0, irq}, 32'd0);
    chk("ack_status", status_word, 32'h0008_000A);
    wr(2'd0, 32'h0000_0002);
    wr(2'd2, 32'h0000_0020);
    run_one("irqcmd", 32'hA5A5_0000, 32'h0000_0020);
    tick(2);
    chk("irq2_irq", {31'd0, irq}, 32'd1);
    chk("irq2_status", status_word, 32'h0009_001A);
    wr(2'd0, 32'h0000_0000);
    tick(2);
    chk("mask_irq", {31'd0, irq}, 32'd0);
    chk("mask_status", status_word, 32'h0009_001A);

    // Push into a full queue on the same edge as a pop
    do_reset();
    wr(2'd1, 32'h0000_1234);
    for (int i = 0; i < 8; i++) wr(2'd2, 32'h30 + i);
    tick(2);
    chk("full_status", status_word, 32'h0000_0805);
    bus.cmd_ready = 1'b1;
    wr(2'd2, 32'h0000_0038);
    bus.cmd_ready = 1'b0;
    tick(2);
    chk("fullpp_status", status_word, 32'h0000_0805);
    pulse_done();
    for (int k = 1; k < 9; k++) run_one($sformatf("fullpp%0d", k), 32'h0000_1234, 32'h30 + k);
    tick(3);
    chk("fullpp_end", status_word, 32'h0009_0002);

    // soft_clear while waiting for done with entries queued
    do_reset();
    wr(2'd0, 32'h0000_0002);
    wr(2'd1, 32'h0000_0055);
    for (int i = 0; i < 4; i++) wr(2'd2, 32'h40 + i);
    tick(2);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    tick(2);
    chk("sc_before", status_word, 32'h0000_0301);
    wr(2'd0, 32'h0000_0001);
    tick(2);
    chk("sc_status", status_word, 32'h0000_0002);
    chk("sc_valid", {31'd0, bus.cmd_valid}, 32'd0);
    pulse_done();
    tick(2);
    chk("sc_stray_done", status_word, 32'h0000_0002);
    wr(2'd2, 32'h0000_0044);
    run_one("sc_cmd", 32'h0000_0000, 32'h0000_0044);
    tick(2);
    chk("sc_irq_en_kept", {31'd0, irq}, 32'd1);
    chk("sc_after", status_word, 32'h0001_0012);

    // done_cnt wrap and ignored done in IDLE
    do_reset();
    dut.done_cnt = 16'hFFFF;
    tick(2);
    chk("wrap_pre", status_word, 32'hFFFF_0002);
    wr(2'd2, 32'h0000_0050);
    run_one("wrap_cmd", 32'h0000_0000, 32'h0000_0050);
    tick(2);
    chk("wrap_post", status_word, 32'h0000_0002);
    pulse_done();
    tick(2);
    chk("idle_done", status_word, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps_pl_cmd_launcher.md
Name: ps_pl_cmd_launcher

Overview:
Sits directly downstream of the PS_PL AXI4-Lite slave register file. It consumes that file's decoded register-write strobes and queues two-word commands from the PS in a FIFO. Commands go one at a time to the transformer core over a valid/ready handshake, and the block waits for the core's done pulse before issuing the next. It returns a status word to the slave's read mux and raises a level interrupt on completion.

Parameters:
DATA_WIDTH, 32, width of register data, command argument and opcode words
FIFO_DEPTH, 8, command queue depth in entries; power of 2, range 2..128

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
reg_wr_en  in  1  one-cycle write strobe from slave register file
reg_wr_addr  in  2  word index of written register (0..3)
reg_wr_data  in  DATA_WIDTH  write data
status_word  out  32  status for slave read mux (register index 3)
cmd_valid  out  1  command offered to core
cmd_ready  in  1  core accepts command
cmd_arg  out  DATA_WIDTH  command argument
cmd_op  out  DATA_WIDTH  command opcode word
core_done  in  1  one-cycle pulse: core finished current command
irq  out  1  level interrupt to PS

Behaviour:
- Register writes, decoded on reg_wr_en:
  - idx0 CTRL: bit0 soft_clear (self-clearing pulse), bit1 irq_en (stored), bit2 irq_ack (pulse).
  - idx1 ARG: stages reg_wr_data into arg_stage.
  - idx2 PUSH: enqueues {arg_stage, reg_wr_data} into the FIFO.
  - idx3: ignored (read-only).
- Reset (ARESET=1 on a clock edge) clears:
  - FIFO (empty, level 0), arg_stage=0, irq_en=0, overflow=0, irq_pending=0, done_cnt=0.
  - FSM forced to IDLE.
  - Outputs: cmd_valid=0, cmd_arg=0, cmd_op=0, irq=0, status_word=0x0000_0002 (empty=1).
- soft_clear: same effect as reset except irq_en, which keeps its value, including when soft_clear is mid-command.
- FIFO:
  - PUSH while full: entry dropped, sticky overflow set.
  - Push and pop in the same cycle while not full: both happen, level unchanged.
  - Push and pop in the same cycle while full: the pop frees space, so the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push at edge N is visible (level, empty) after edge N.
- FSM:
  - IDLE: if FIFO not empty, register head into cmd_arg/cmd_op, set cmd_valid=1, go to ISSUE. A command pushed at edge N gives cmd_valid=1 after edge N+1.
  - ISSUE: hold cmd_valid and data stable until cmd_ready=1. On cmd_valid&cmd_ready: pop FIFO, cmd_valid=0, go to WAIT_DONE.
  - WAIT_DONE: on core_done, increment done_cnt, set irq_pending if irq_en=1, go to IDLE.
  - core_done outside WAIT_DONE is ignored, including the handshake cycle and a stray pulse after soft_clear.
  - Back-to-back commands: one idle cycle minimum between done and the next cmd_valid.
- irq_pending:
  - irq_ack clears it.
  - If irq_ack and a qualifying core_done occur in the same cycle, set wins.
  - irq = irq_pending & irq_en. Clearing irq_en masks irq but does not clear pending.
- done_cnt: 16-bit, wraps 0xFFFF -> 0x0000.
- status_word, registered, updated every cycle:
  - [0] busy (FSM != IDLE)
  - [1] fifo_empty
  - [2] fifo_full
  - [3] overflow
  - [4] irq_pending
  - [7:5] 0
  - [15:8] fifo level, zero-extended
  - [31:16] done_cnt

Test Plan:
- Reset, then write idx1=0xA5A5_0001 and idx2=0x0000_0010, cmd_ready=1 -> cmd_valid high 2 cycles after the PUSH strobe with arg 0xA5A5_0001 / op 0x10. After core_done: status_word[31:16]=1, busy=0.
- irq_en=1 via CTRL=0x2, run one command -> irq=1 and status[4]=1. CTRL=0x4 -> irq=0. CTRL=0x0 with pending set -> irq masked, status[4] stays 1.
- cmd_ready=0, push 9 commands with DEPTH=8 -> level=8, full=1, overflow=1. Release cmd_ready and pulse done 8 times -> exactly 8 issued in push order, done_cnt=8.
- Push exactly when FIFO is full and a pop occurs the same cycle -> level stays 8, overflow stays 0.
- soft_clear during WAIT_DONE with 3 entries queued -> level=0, busy=0, done_cnt=0, irq_en retained. A following core_done does not increment done_cnt.
- Force done_cnt to 0xFFFF (65535 completions or a preloaded backdoor), one more done -> done_cnt=0x0000. core_done pulsed in IDLE -> no change.
